// File: rtl/dma_uart_tx_pkg.sv
// Shared types and constants for the DMA-driven UART transmitter.
// Holds the DMA FSM states, serializer states and the buffer addresses.
package dma_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    MSB_ADDR,
    MSB_SEND,
    MSB_WAIT,
    LSB_ADDR,
    LSB_SEND,
    LSB_WAIT
  } dma_state_t;

  typedef enum logic {
    UART_IDLE,
    UART_BUSY
  } uart_state_t;

  localparam logic [7:0] DMA_TX_MSB_ADDR = 8'h04;
  localparam logic [7:0] DMA_TX_LSB_ADDR = 8'h05;
  localparam logic [7:0] DMA_IDLE_ADDR   = 8'h00;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  function automatic int calc_bit_cycles(input int freq_clk, input int tx_speed);
    return freq_clk / tx_speed;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer: accepts one byte per tx_valid while idle and shifts
// it out LSB first, each bit held for FREQ_CLK/TX_SPEED clocks.
module uart_tx
  import dma_uart_tx_pkg::*;
#(
  parameter int FREQ_CLK = 100000000,
  parameter int TX_SPEED = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  localparam int BIT_CYCLES = calc_bit_cycles(FREQ_CLK, TX_SPEED);
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  uart_state_t state;
  logic [FRAME_BITS-1:0] frame;
  logic [3:0] bit_cnt;
  logic [CYC_W-1:0] cyc_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UART_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      tx_ready <= 1'b1;
      txd      <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          if (tx_valid) begin
            frame    <= {1'b1, tx_data, 1'b0};
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            state    <= UART_BUSY;
          end
        end
        UART_BUSY: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              // Stop bit finished: line returns to idle on the same edge.
              state    <= UART_IDLE;
              tx_ready <= 1'b1;
              txd      <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              frame   <= {1'b1, frame[FRAME_BITS-1:1]};
              txd     <= frame[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          state    <= UART_IDLE;
          tx_ready <= 1'b1;
          txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dma_uart_tx.sv
// DMA front end that fetches a 2-byte buffer (0x04 then 0x05) from memory
// over an arbitrated bus and streams both bytes out through uart_tx.
module dma_uart_tx
  import dma_uart_tx_pkg::*;
#(
  parameter int FREQ_CLK = 100000000,
  parameter int TX_SPEED = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       bus_grant,
  input  logic [7:0] databus,
  output logic [7:0] address,
  output logic       cs,
  output logic       oen,
  output logic       bus_req,
  output logic       dma_ready,
  output logic       tx_ready,
  output logic       txd
);

  dma_state_t state;
  logic       tx_valid;
  logic [7:0] tx_byte;

  // All FSM outputs are registered and updated on the transition into the
  // state that owns them; bus_req is held from REQ until the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      address   <= DMA_IDLE_ADDR;
      cs        <= 1'b0;
      oen       <= 1'b1;
      bus_req   <= 1'b0;
      dma_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ena && start) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            dma_ready <= 1'b0;
          end
        end
        REQ: begin
          if (bus_grant) begin
            state   <= MSB_ADDR;
            address <= DMA_TX_MSB_ADDR;
            cs      <= 1'b1;
            oen     <= 1'b0;
          end
        end
        MSB_ADDR: begin
          tx_byte  <= databus;
          address  <= DMA_IDLE_ADDR;
          cs       <= 1'b0;
          oen      <= 1'b1;
          tx_valid <= 1'b1;
          state    <= MSB_SEND;
        end
        MSB_SEND: begin
          tx_valid <= 1'b0;
          state    <= MSB_WAIT;
        end
        MSB_WAIT: begin
          // The serializer is already busy on entry, so ready here means done.
          if (tx_ready) begin
            state   <= LSB_ADDR;
            address <= DMA_TX_LSB_ADDR;
            cs      <= 1'b1;
            oen     <= 1'b0;
          end
        end
        LSB_ADDR: begin
          tx_byte  <= databus;
          address  <= DMA_IDLE_ADDR;
          cs       <= 1'b0;
          oen      <= 1'b1;
          tx_valid <= 1'b1;
          state    <= LSB_SEND;
        end
        LSB_SEND: begin
          tx_valid <= 1'b0;
          state    <= LSB_WAIT;
        end
        LSB_WAIT: begin
          if (tx_ready) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            dma_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          address   <= DMA_IDLE_ADDR;
          cs        <= 1'b0;
          oen       <= 1'b1;
          bus_req   <= 1'b0;
          dma_ready <= 1'b1;
          tx_valid  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx #(
    .FREQ_CLK(FREQ_CLK),
    .TX_SPEED(TX_SPEED)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_valid(tx_valid),
    .tx_data (tx_byte),
    .tx_ready(tx_ready),
    .txd     (txd)
  );

endmodule

// File: tb/tb_dma_uart_tx.sv
// Self-checking bench for dma_uart_tx: expected serial bits are queued when
// memory data is presented and popped as the line is sampled mid-bit.
module tb_dma_uart_tx;

  localparam int FREQ_CLK = 100000000;
  localparam int TX_SPEED = 115200;
  localparam int BC = 868;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       bus_grant;
  logic [7:0] databus;
  logic [7:0] address;
  logic       cs;
  logic       oen;
  logic       bus_req;
  logic       dma_ready;
  logic       tx_ready;
  logic       txd;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  dma_uart_tx #(
    .FREQ_CLK(FREQ_CLK),
    .TX_SPEED(TX_SPEED)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .bus_grant(bus_grant),
    .databus  (databus),
    .address  (address),
    .cs       (cs),
    .oen      (oen),
    .bus_req  (bus_req),
    .dma_ready(dma_ready),
    .tx_ready (tx_ready),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Waits for the serializer to go busy, then samples every bit mid-period.
  task automatic check_frame(input string name);
    int n;
    logic exp;
    n = 0;
    while (tx_ready === 1'b1 && n < 16) begin
      tick();
      n++;
    end
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_start tx_ready got %b want 0", name, tx_ready);
      return;
    end
    repeat (BC / 2) tick();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_bit%0d scoreboard empty", name, i);
      end else begin
        exp = exp_q.pop_front();
        if (txd !== exp) begin
          miscompares++;
          $display("FAIL %s_bit%0d txd got %b want %b", name, i, txd, exp);
        end
      end
      if (i == 4) begin
        vectors++;
        if (tx_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_busy tx_ready got %b want 0", name, tx_ready);
        end
      end
      if (i < 9) repeat (BC) tick();
    end
    n = 0;
    while (tx_ready !== 1'b1 && n < BC) begin
      tick();
      n++;
    end
    vectors++;
    if (n != BC - BC / 2 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_rise cycles got %0d want %0d (tx_ready=%b)",
               name, n, BC - BC / 2, tx_ready);
    end
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle_line txd got %b want 1", name, txd);
    end
  endtask

  task automatic do_transfer(input logic [7:0] msb, input logic [7:0] lsb,
                             input bit drop_ena, input string name);
    ena = 1'b1;
    databus = msb;
    push_frame(msb);
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (bus_req !== 1'b1 || dma_ready !== 1'b0 || cs !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_req bus_req/dma_ready/cs got %b%b%b want 100",
               name, bus_req, dma_ready, cs);
    end
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    if (drop_ena) ena = 1'b0;
    vectors++;
    if (address !== 8'h04 || cs !== 1'b1 || oen !== 1'b0 || bus_req !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_msb_strobe addr=%h cs=%b oen=%b req=%b want 04 1 0 1",
               name, address, cs, oen, bus_req);
    end
    tick();
    vectors++;
    if (cs !== 1'b0 || oen !== 1'b1 || address !== 8'h00) begin
      miscompares++;
      $display("FAIL %s_msb_release addr=%h cs=%b oen=%b want 00 0 1",
               name, address, cs, oen);
    end
    check_frame({name, "_msb"});
    vectors++;
    if (bus_req !== 1'b1 || dma_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_mid bus_req=%b dma_ready=%b want 1 0", name, bus_req, dma_ready);
    end
    tick();
    databus = lsb;
    push_frame(lsb);
    vectors++;
    if (address !== 8'h05 || cs !== 1'b1 || oen !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_lsb_strobe addr=%h cs=%b oen=%b want 05 1 0",
               name, address, cs, oen);
    end
    check_frame({name, "_lsb"});
    tick();
    vectors++;
    if (dma_ready !== 1'b1 || bus_req !== 1'b0 || address !== 8'h00) begin
      miscompares++;
      $display("FAIL %s_done dma_ready=%b bus_req=%b addr=%h want 1 0 00",
               name, dma_ready, bus_req, address);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) tick();
    vectors++;
    if (address !== 8'h00 || cs !== 1'b0 || oen !== 1'b1 || bus_req !== 1'b0 ||
        dma_ready !== 1'b1 || tx_ready !== 1'b1 || txd !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values addr=%h cs=%b oen=%b req=%b dr=%b tr=%b txd=%b",
               address, cs, oen, bus_req, dma_ready, tx_ready, txd);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (dma_ready !== 1'b1 || txd !== 1'b1 || bus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release dr=%b txd=%b req=%b want 1 1 0",
               dma_ready, txd, bus_req);
    end
  endtask

  task automatic test_ignored_start();
    ena = 1'b0;
    start = 1'b1;
    bus_grant = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus_grant = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus_req !== 1'b0 || dma_ready !== 1'b1 || cs !== 1'b0 ||
        address !== 8'h00 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ena_low req=%b dr=%b cs=%b addr=%h tr=%b",
               bus_req, dma_ready, cs, address, tx_ready);
    end
  endtask

  task automatic test_transfer();
    do_transfer(8'hAA, 8'hBB, 1'b1, "xfer");
  endtask

  task automatic test_reset_mid();
    int n;
    ena = 1'b1;
    databus = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    n = 0;
    while (tx_ready === 1'b1 && n < 16) begin
      tick();
      n++;
    end
    repeat (BC + BC / 2) tick();
    // Mid start of data bit 0 of 0x5A, which is 0.
    vectors++;
    if (txd !== 1'b0 || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_line txd=%b tr=%b want 0 0", txd, tx_ready);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (bus_req !== 1'b1 || dma_ready !== 1'b0 || cs !== 1'b0 || address !== 8'h00) begin
      miscompares++;
      $display("FAIL start_busy req=%b dr=%b cs=%b addr=%h want 1 0 0 00",
               bus_req, dma_ready, cs, address);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || dma_ready !== 1'b1 || bus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset txd=%b tr=%b dr=%b req=%b want 1 1 1 0",
               txd, tx_ready, dma_ready, bus_req);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    do_transfer(8'h3C, 8'hC3, 1'b0, "after_rst");
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b0;
    start = 1'b0;
    bus_grant = 1'b0;
    databus = 8'h00;
    test_reset();
    test_ignored_start();
    test_transfer();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
